// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serialiser state encoding.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by an MMIO peripheral: address/data/strobes from
// the CPU, read data and window hit back to the CPU read mux.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output addr, wdata, mem_write, mem_read,
        input  rdata, hit
    );

    modport slave (
        input  addr, wdata, mem_write, mem_read,
        output rdata, hit
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head is visible on rdata whenever
// the FIFO is non-empty. Synchronous active-low reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = count_q == CntW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes CPU stores into a TX FIFO and
// serialises bytes on txd at BAUD_DIV clocks per bit.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          txd,
    output logic          tx_idle
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e     state_q;
    logic [15:0]     cnt_q, baud_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            overflow_q;

    logic [1:0]      offset;
    logic            wr_en, wr_txdata, wr_status, wr_baud;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]      fifo_head;
    logic [CntW-1:0] fifo_count;
    logic [31:0]     count_ext, status, rdata_d;
    logic            last_tick, idle_next, empty_next;
    logic            unused_bits;

    assign offset    = bus.addr[3:2];
    assign bus.hit   = bus.addr[31:4] == BASE_ADDR[31:4];
    assign wr_en     = bus.mem_write && bus.hit;
    assign wr_txdata = wr_en && offset == OFF_TXDATA;
    assign wr_status = wr_en && offset == OFF_STATUS;
    assign wr_baud   = wr_en && offset == OFF_BAUD;
    assign last_tick = cnt_q == 16'd1;

    // Full is sampled before this edge's pop, so a pop never rescues a write.
    assign fifo_push = wr_txdata && !fifo_full;
    assign fifo_pop  = !fifo_empty &&
                       (state_q == StIdle || (state_q == StStop && last_tick));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (bus.wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        empty_next = fifo_pop ? (fifo_count == CntW'(1) && !fifo_push)
                              : (fifo_empty && !fifo_push);
        idle_next  = fifo_empty &&
                     (state_q == StIdle || (state_q == StStop && last_tick));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            baud_q     <= DEFAULT_DIV;
        end else begin
            if (wr_txdata && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (wr_status && bus.wdata[ST_OVF]) begin
                overflow_q <= 1'b0;
            end
            if (wr_baud) baud_q <= (bus.wdata[15:0] == 16'd0) ? 16'd1 : bus.wdata[15:0];
        end
    end

    // Counter reloads from baud_q at every bit start, so divider writes land
    // on the next bit boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd       <= 1'b1;
            tx_idle   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StStart;
                        shift_q <= fifo_head;
                        cnt_q   <= baud_q;
                        txd     <= 1'b0;
                    end
                end
                StStart: begin
                    if (last_tick) begin
                        state_q   <= StData;
                        bit_idx_q <= 3'd0;
                        cnt_q     <= baud_q;
                        txd       <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StData: begin
                    if (last_tick) begin
                        cnt_q <= baud_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                            txd     <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd       <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                StStop: begin
                    if (last_tick) begin
                        if (!fifo_empty) begin
                            state_q <= StStart;
                            shift_q <= fifo_head;
                            cnt_q   <= baud_q;
                            txd     <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
            tx_idle <= idle_next && empty_next;
        end
    end

    assign count_ext = 32'(fifo_count);

    always_comb begin
        status                      = '0;
        status[ST_BUSY]             = state_q != StIdle;
        status[ST_FULL]             = fifo_full;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_OVF]              = overflow_q;
        status[ST_CNT_LSB +: 4]     = count_ext[3:0];
        rdata_d                     = '0;
        if (bus.hit && bus.mem_read) begin
            case (offset)
                OFF_STATUS: rdata_d = status;
                OFF_BAUD:   rdata_d = {16'd0, baud_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    assign bus.rdata   = rdata_d;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:16], count_ext[31:4]};
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised self-checking bench: a timeline model schedules each accepted
// byte as a 10-bit frame and predicts txd, tx_idle and register reads.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 8;
    localparam int          MAXC  = 12000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic txd, tx_idle;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .txd     (txd),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_rdata;

    // Model: each frame occupies edges [start, end); the byte sits in the FIFO
    // for edges before start.
    int m_start[$];
    int m_end[$];
    int m_div      = 4;
    bit m_ovf      = 1'b0;
    int m_last_end = 0;
    bit exp_txd[MAXC];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int m_count(input int t);
        int n = 0;
        foreach (m_start[i]) if (m_start[i] > t) n++;
        return n;
    endfunction

    function automatic bit m_busy(input int t);
        foreach (m_start[i]) if (m_start[i] <= t && t < m_end[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_idle(input int t);
        return !m_busy(t) && m_count(t) == 0;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input int t);
        int          n;
        logic [31:0] v = '0;
        if (!m_hit(a)) return '0;
        n = m_count(t);
        case (a[3:2])
            2'd1: begin
                v[0]    = m_busy(t);
                v[1]    = n == DEPTH;
                v[2]    = n == 0;
                v[3]    = m_ovf;
                v[11:8] = n[3:0];
            end
            2'd2:    v = 32'(m_div);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic m_reset(input int e);
        m_start.delete();
        m_end.delete();
        m_last_end = 0;
        m_ovf      = 1'b0;
        m_div      = 4;
        for (int t = e; t < MAXC; t++) exp_txd[t] = 1'b1;
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input int e);
        int s, len, bi;
        case (a[3:2])
            2'd0: begin
                if (m_count(e - 1) < DEPTH) begin
                    s   = (e + 1 > m_last_end) ? e + 1 : m_last_end;
                    len = 10 * m_div;
                    for (int k = 0; k < len; k++) begin
                        bi = k / m_div;
                        if (s + k < MAXC)
                            exp_txd[s + k] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : d[bi - 1];
                    end
                    m_start.push_back(s);
                    m_end.push_back(s + len);
                    m_last_end = s + len;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            2'd1: if (d[3]) m_ovf = 1'b0;
            2'd2: m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
            default: ;
        endcase
    endtask

    task automatic step(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        int e;
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_write = w;
        bus.mem_read  = r;
        #1;
        last_rdata = bus.rdata;
        check_eq("hit", 32'(bus.hit), 32'(m_hit(a)));
        check_eq("rdata", bus.rdata, r ? m_read(a, cyc) : 32'd0);
        e = cyc + 1;
        if (!rst) m_reset(e);
        else if (w && m_hit(a)) m_write(a, d, e);
        @(posedge clk);
        cyc = e;
        #1;
        check_eq("txd", 32'(txd), 32'((cyc < MAXC) ? exp_txd[cyc] : 1'b1));
        check_eq("tx_idle", 32'(tx_idle), 32'(m_idle(cyc)));
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        step(1'b1, 1'b0, BASE + 32'(off) * 4, d);
    endtask

    task automatic rd(input int off);
        step(1'b0, 1'b1, BASE + 32'(off) * 4, 32'h0);
    endtask

    task automatic drain();
        int i = 0;
        while (i < 3000 && !m_idle(cyc)) begin
            nop();
            i++;
        end
        repeat (3) nop();
        check_eq("drained_idle", 32'(tx_idle), 32'd1);
    endtask

    task automatic random_phase(input int cycles);
        int          sel;
        logic [31:0] d;
        logic [31:0] lo;
        for (int i = 0; i < cycles; i++) begin
            sel = $urandom_range(0, 99);
            d   = $urandom;
            lo  = 32'($urandom_range(0, 3));
            if (sel < 30)      step(1'b1, 1'b0, BASE + lo, d);
            else if (sel < 40) step(1'b0, 1'b1, BASE + 32'($urandom_range(0, 3)) * 4 + lo, 32'h0);
            else if (sel < 44) step(1'b1, 1'b0, 32'h0000_0110 + lo, d);
            else if (sel < 47) step(1'b1, 1'b0, BASE + 32'h4 + lo, d);
            else if (sel < 49) step(1'b1, 1'b0, BASE + 32'hC + lo, d);
            else if (sel < 52) step(1'b0, 1'b1, 32'h0000_00F4, 32'h0);
            else               nop();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_e, s;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;

        rst = 1'b0;
        nop();
        nop();
        rst = 1'b1;
        nop();
        rd(1);
        check_eq("status_after_reset", last_rdata, 32'h0000_0004);
        rd(2);
        check_eq("baud_after_reset", last_rdata, 32'd4);

        wr(0, 32'h55);
        repeat (45) nop();

        wr(0, 32'h41);
        wr(0, 32'h42);
        rd(1);
        check_eq("b2b_count", 32'(last_rdata[11:8]), 32'd1);
        drain();

        wr(0, 32'h10);
        nop();
        for (int i = 0; i < 9; i++) wr(0, 32'($urandom_range(0, 255)));
        rd(1);
        check_eq("ovf_set", 32'(last_rdata[3]), 32'd1);
        check_eq("full_set", 32'(last_rdata[1]), 32'd1);
        wr(1, 32'h8);
        rd(1);
        check_eq("ovf_cleared", 32'(last_rdata[3]), 32'd0);
        drain();

        wr(2, 32'h0);
        rd(2);
        check_eq("baud_zero_is_one", last_rdata, 32'd1);
        wr(0, 32'hFF);
        repeat (14) nop();

        for (int r = 0; r < 3; r++) begin
            wr(2, 32'($urandom_range(1, 6)));
            random_phase(250);
            drain();
        end

        wr(2, 32'd4);
        first_e = cyc + 1;
        wr(0, 32'hA5);
        wr(0, 32'h3C);
        wr(0, 32'h96);
        s = first_e + 1;
        while (cyc < s + 17) nop();
        rst = 1'b0;
        nop();
        check_eq("txd_after_reset_edge", 32'(txd), 32'd1);
        nop();
        rst = 1'b1;
        rd(1);
        check_eq("count_after_reset", 32'(last_rdata[11:8]), 32'd0);
        repeat (100) nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
